// File: rtl/cordic_magsq_pre.sv
// Magnitude-squared front end for the CORDIC sqrt stage: dout = I*I + Q*Q, computed
// with a bit-serial shift-add multiplier that reuses one accumulator for both squares.
module cordic_magsq_pre #(
  parameter int W     = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     i_in,
  input  logic [W-1:0]     q_in,
  input  logic             vld_in,
  output logic             in_rdy,
  input  logic             dn_busy,
  output logic [2*W-1:0]   dout,
  output logic             vld_out,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int KW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL_I = 2'd1,
    MUL_Q = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [W-1:0]       mi, mi_nxt;
  logic [W-1:0]       mq, mq_nxt;
  logic [2*W-1:0]     acc, acc_nxt;
  logic [KW-1:0]      k, k_nxt;
  logic [2*W-1:0]     dout_nxt;
  logic               vld_nxt;
  logic [CNT_W-1:0]   drop_nxt;
  logic [W-1:0]       cur;
  logic [2*W-1:0]     partial;
  logic               last_bit;

  // |x| as unsigned; the most negative input maps to 2^(W-1), which still fits in W bits.
  function automatic logic [W-1:0] abs_val(input logic [W-1:0] x);
    if (x[W-1]) begin
      abs_val = ~x + {{(W-1){1'b0}}, 1'b1};
    end else begin
      abs_val = x;
    end
  endfunction

  assign in_rdy = (state == IDLE);

  // Next-state, datapath and drop-counter logic
  always_comb begin
    state_nxt = state;
    mi_nxt    = mi;
    mq_nxt    = mq;
    acc_nxt   = acc;
    k_nxt     = k;
    dout_nxt  = dout;
    vld_nxt   = 1'b0;
    cur       = (state == MUL_Q) ? mq : mi;
    partial   = {{W{1'b0}}, cur} << k;
    last_bit  = (k == KW'(W - 1));

    case (state)
      IDLE: begin
        if (vld_in) begin
          mi_nxt    = abs_val(i_in);
          mq_nxt    = abs_val(q_in);
          acc_nxt   = {(2*W){1'b0}};
          k_nxt     = {KW{1'b0}};
          state_nxt = MUL_I;
        end else begin
          state_nxt = IDLE;
        end
      end
      MUL_I, MUL_Q: begin
        if (cur[k]) begin
          acc_nxt = acc + partial;
        end else begin
          acc_nxt = acc;
        end
        if (last_bit) begin
          k_nxt     = {KW{1'b0}};
          state_nxt = (state == MUL_I) ? MUL_Q : OUT;
        end else begin
          k_nxt     = k + {{(KW-1){1'b0}}, 1'b1};
          state_nxt = state;
        end
      end
      OUT: begin
        // Result is held in acc until the sqrt stage is free to take it.
        if (!dn_busy) begin
          dout_nxt  = acc;
          vld_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          vld_nxt   = 1'b0;
          state_nxt = OUT;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (vld_in && (state != IDLE) && (drop_cnt != {CNT_W{1'b1}})) begin
      drop_nxt = drop_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      drop_nxt = drop_cnt;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mi       <= {W{1'b0}};
      mq       <= {W{1'b0}};
      acc      <= {(2*W){1'b0}};
      k        <= {KW{1'b0}};
      dout     <= {(2*W){1'b0}};
      vld_out  <= 1'b0;
      drop_cnt <= {CNT_W{1'b0}};
    end else begin
      mi       <= mi_nxt;
      mq       <= mq_nxt;
      acc      <= acc_nxt;
      k        <= k_nxt;
      dout     <= dout_nxt;
      vld_out  <= vld_nxt;
      drop_cnt <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_cordic_magsq_pre.sv
// Self-checking bench for cordic_magsq_pre: directed corner cases, back-pressure,
// continuous-valid drop counting, mid-operation reset and random I/Q against I*I+Q*Q.
module tb_cordic_magsq_pre;

  localparam int W     = 16;
  localparam int CNT_W = 8;
  localparam int LAT   = 2 * W + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [W-1:0]     i_in;
  logic [W-1:0]     q_in;
  logic             vld_in;
  logic             in_rdy;
  logic             dn_busy;
  logic [2*W-1:0]   dout;
  logic             vld_out;
  logic [CNT_W-1:0] drop_cnt;

  int errors = 0;
  int checks = 0;

  cordic_magsq_pre #(.W(W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_in     (i_in),
    .q_in     (q_in),
    .vld_in   (vld_in),
    .in_rdy   (in_rdy),
    .dn_busy  (dn_busy),
    .dout     (dout),
    .vld_out  (vld_out),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] magsq(input logic [W-1:0] i, input logic [W-1:0] q);
    longint si;
    longint sq;
    si = longint'($signed(i));
    sq = longint'($signed(q));
    return 32'(si * si + sq * sq);
  endfunction

  // One sample from idle: checks latency, in_rdy low time, dout and single-cycle pulse.
  task automatic do_sample(input logic [W-1:0] i, input logic [W-1:0] q,
                           input int busy, input string tag);
    int cnt;
    int rdy_low;
    i_in   = i;
    q_in   = q;
    vld_in = 1'b1;
    @(posedge clk); #1;
    vld_in = 1'b0;
    if (busy > 0) dn_busy = 1'b1;
    cnt     = 0;
    rdy_low = in_rdy ? 0 : 1;
    while (!vld_out && cnt < 200) begin
      if (busy > 0 && cnt == LAT - 1 + busy) dn_busy = 1'b0;
      @(posedge clk); #1;
      cnt++;
      if (!in_rdy) rdy_low++;
    end
    dn_busy = 1'b0;
    chk({tag, "_latency"}, 64'(cnt), 64'(LAT + busy));
    chk({tag, "_rdy_low"}, 64'(rdy_low), 64'(LAT + busy));
    chk({tag, "_dout"}, 64'(dout), 64'(magsq(i, q)));
    @(posedge clk); #1;
    chk({tag, "_single_pulse"}, 64'(vld_out), 64'd0);
  endtask

  function automatic logic [W-1:0] seq_i(input int n);
    return 16'(n * 211 - 30000);
  endfunction

  function automatic logic [W-1:0] seq_q(input int n);
    return 16'(32767 - n * 173);
  endfunction

  initial begin
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;
    logic        rdy_prev;
    int          acc_cnt;
    int          res_cnt;
    int          cyc;
    int          last_vld;
    int          mdrop;
    int          seen;

    rst_n   = 1'b0;
    i_in    = '0;
    q_in    = '0;
    vld_in  = 1'b0;
    dn_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    chk("rst_vld_out", 64'(vld_out), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic and arithmetic corners
    do_sample(16'd3, 16'd4, 0, "t1_3_4");
    chk("t1_drop_cnt", 64'(drop_cnt), 64'd0);
    do_sample(16'h8000, 16'h8000, 0, "t2_min_min");
    chk("t2_min_min_const", 64'(dout), 64'h8000_0000);
    do_sample(16'h0000, 16'h0000, 0, "t2_zero");
    do_sample(16'hFFFF, 16'h7FFF, 0, "t2_m1_max");
    chk("t2_m1_max_const", 64'(dout), 64'h3FFF_0002);

    // Back-pressure held five cycles in OUT
    do_sample(16'd1234, 16'hF00D, 5, "t3_busy5");

    // Continuous valid: one accept per 2W+2 cycles, drops saturate
    acc_cnt  = 0;
    res_cnt  = 0;
    cyc      = 0;
    last_vld = -1;
    mdrop    = 0;
    i_in     = seq_i(0);
    q_in     = seq_q(0);
    vld_in   = 1'b1;
    while (res_cnt < 300 && cyc < 20000) begin
      rdy_prev = in_rdy;
      @(posedge clk); #1;
      cyc++;
      if (vld_in) begin
        if (rdy_prev) begin
          exp_q.push_back(magsq(i_in, q_in));
          acc_cnt++;
          if (acc_cnt < 300) begin
            i_in = seq_i(acc_cnt);
            q_in = seq_q(acc_cnt);
          end else begin
            vld_in = 1'b0;
          end
        end else if (mdrop < 255) begin
          mdrop++;
        end
      end
      if (vld_out) begin
        if (exp_q.size() == 0) exp_v = 32'hDEAD_BEEF;
        else exp_v = exp_q.pop_front();
        chk("t4_dout", 64'(dout), 64'(exp_v));
        if (last_vld >= 0) chk("t4_interval", 64'(cyc - last_vld), 64'(2 * W + 2));
        chk("t4_drop_track", 64'(drop_cnt), 64'(mdrop));
        last_vld = cyc;
        res_cnt++;
      end
    end
    vld_in = 1'b0;
    chk("t4_results", 64'(res_cnt), 64'd300);
    chk("t4_drop_sat", 64'(drop_cnt), 64'd255);
    @(posedge clk); #1;

    // Reset during MUL_Q abandons the computation
    i_in   = 16'd100;
    q_in   = 16'd200;
    vld_in = 1'b1;
    @(posedge clk); #1;
    vld_in = 1'b0;
    repeat (W + 4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_in_rdy", 64'(in_rdy), 64'd1);
    chk("t5_vld_out", 64'(vld_out), 64'd0);
    chk("t5_dout", 64'(dout), 64'd0);
    chk("t5_drop_cnt", 64'(drop_cnt), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen  = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (vld_out) seen++;
    end
    chk("t5_no_pulse", 64'(seen), 64'd0);
    do_sample(16'hFF9C, 16'd200, 0, "t5_after");

    // Random samples with occasional back-pressure
    for (int n = 0; n < 1000; n++) begin
      do_sample(16'($urandom), 16'($urandom), int'($urandom_range(0, 2)), "t6_rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
